// File: rtl/rv_pkg.sv
// Shared RV32I subset constants, ALU encodings and the fetch/execute state type.
package rv_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational decode of the held instruction word into datapath controls,
// the branch offset and an illegal-encoding flag.
module rv_decoder
  import rv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  rs1,
  output logic [5:0]  rs2,
  output logic [5:0]  rd,
  output logic [31:0] imm_i,
  output logic [31:0] imm_b,
  output logic        alu_src,
  output logic        alu_ctrl,
  output logic        wr_en,
  output logic        is_bne,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign rs1   = {1'b0, ir[19:15]};
  assign rs2   = {1'b0, ir[24:20]};
  assign rd    = {1'b0, ir[11:7]};
  assign imm_i = sext12(ir[31:20]);
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  always_comb begin
    alu_src  = 1'b0;
    alu_ctrl = ALU_ADD;
    wr_en    = 1'b0;
    is_bne   = 1'b0;
    illegal  = 1'b1;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          alu_src = 1'b1;
          wr_en   = 1'b1;
          illegal = 1'b0;
        end
      end
      OP_REG: begin
        if (funct3 == F3_ADD_SUB && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
          alu_ctrl = funct7[5];
          wr_en    = 1'b1;
          illegal  = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BNE) begin
          alu_ctrl = ALU_SUB;
          is_bne   = 1'b1;
          illegal  = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl_unit.sv
// Fetch/execute controller: owns PC and IR, fetches from imem, drives datapath controls.
// FETCH_CTRL_TRAP_EN: illegal instructions halt the core instead of executing as NOP.
module fetch_ctrl_unit
  import rv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              eq_out,
  output logic [5:0]        rs1,
  output logic [5:0]        rs2,
  output logic [5:0]        rd,
  output logic              reg_write,
  output logic [31:0]       imm_op,
  output logic              alu_src,
  output logic              alu_ctrl,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [31:0]       ir;

  logic [5:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm_i, d_imm_b;
  logic        d_alu_src, d_alu_ctrl, d_wr_en, d_is_bne, d_illegal;

  rv_decoder u_dec (
    .ir       (ir),
    .rs1      (d_rs1),
    .rs2      (d_rs2),
    .rd       (d_rd),
    .imm_i    (d_imm_i),
    .imm_b    (d_imm_b),
    .alu_src  (d_alu_src),
    .alu_ctrl (d_alu_ctrl),
    .wr_en    (d_wr_en),
    .is_bne   (d_is_bne),
    .illegal  (d_illegal)
  );

  logic              taken;
  logic [ADDR_W-1:0] seq_pc, br_pc, tgt_pc;

  assign taken  = d_is_bne & ~eq_out;
  assign seq_pc = pc + ADDR_W'(4);
  assign br_pc  = pc + ADDR_W'($signed(d_imm_b));
  assign tgt_pc = taken ? br_pc : seq_pc;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      FETCH: begin
        if (imem_ack) state_next = EXEC;
      end
      EXEC: begin
`ifdef FETCH_CTRL_TRAP_EN
        if (d_illegal) begin
          state_next = HALT;
        end else begin
          state_next = FETCH;
          pc_next    = {tgt_pc[ADDR_W-1:2], 2'b00};
        end
`else
        state_next = FETCH;
        pc_next    = {tgt_pc[ADDR_W-1:2], 2'b00};
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= NOP_INSTR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
    end
  end

  // Reset forces every control output low in the same cycle, regardless of state.
  assign imem_req  = ~rst & (state == FETCH);
  assign imem_addr = pc;
  assign reg_write = ~rst & (state == EXEC) & d_wr_en;
  assign rs1       = rst ? '0 : d_rs1;
  assign rs2       = rst ? '0 : d_rs2;
  assign rd        = rst ? '0 : d_rd;
  assign imm_op    = rst ? '0 : d_imm_i;
  assign alu_src   = ~rst & d_alu_src;
  assign alu_ctrl  = ~rst & d_alu_ctrl;

`ifdef FETCH_CTRL_TRAP_EN
  assign halted = ~rst & (state == HALT);
`else
  logic illegal_unused;
  assign illegal_unused = d_illegal;
  assign halted         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Self-checking bench for fetch_ctrl_unit: directed scenarios plus randomized
// instruction streams compared cycle by cycle against an instruction-level model.
module tb_fetch_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst, imem_ack, eq_out;
  logic [31:0] imem_rdata;
  logic        imem_req, reg_write, alu_src, alu_ctrl, halted;
  logic [31:0] imem_addr, imm_op, pc;
  logic [5:0]  rs1, rs2, rd;

  fetch_ctrl_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .eq_out(eq_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .imm_op(imm_op),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Per-cycle expectations, set by the stimulus just after each rising edge.
  bit          e_on, e_halt_on, e_pc_on, e_addr_on, e_rs1_on, e_rs2_on, e_rd_on, e_imm_on, e_alu_on;
  logic        e_req, e_rw, e_halted, e_src, e_ctrl;
  logic [31:0] e_pc, e_addr, e_imm;
  logic [5:0]  e_rs1, e_rs2, e_rd;
  int          e_lit, lit_kind;
  logic [5:0]  lit_rs1, lit_rs2, lit_rd;
  logic [31:0] lit_imm;
  logic        lit_src, lit_ctrl, lit_rw;

  always @(negedge clk) begin
    if (e_on) begin
      check("imem_req", imem_req, e_req);
      check("reg_write", reg_write, e_rw);
      if (e_halt_on) check("halted", halted, e_halted);
      if (e_pc_on)   check("pc", pc, e_pc);
      if (e_addr_on) check("imem_addr", imem_addr, e_addr);
      if (e_rs1_on)  check("rs1", rs1, e_rs1);
      if (e_rs2_on)  check("rs2", rs2, e_rs2);
      if (e_rd_on)   check("rd", rd, e_rd);
      if (e_imm_on)  check("imm_op", imm_op, e_imm);
      if (e_alu_on) begin
        check("alu_src", alu_src, e_src);
        check("alu_ctrl", alu_ctrl, e_ctrl);
      end
      if (e_lit == 1) begin
        check("lit_addi_rd", rd, lit_rd);
        check("lit_addi_imm", imm_op, lit_imm);
        check("lit_addi_src", alu_src, lit_src);
        check("lit_addi_ctrl", alu_ctrl, lit_ctrl);
        check("lit_addi_rw", reg_write, lit_rw);
      end else if (e_lit == 2) begin
        check("lit_sub_rs1", rs1, lit_rs1);
        check("lit_sub_rs2", rs2, lit_rs2);
        check("lit_sub_rd", rd, lit_rd);
        check("lit_sub_src", alu_src, lit_src);
        check("lit_sub_ctrl", alu_ctrl, lit_ctrl);
        check("lit_sub_rw", reg_write, lit_rw);
      end
    end
  end

  // Instruction-level reference model.
  logic [31:0] m_pc;

  function automatic void model(input logic [31:0] w, output bit legal, output bit wr,
                                output bit src, output bit ctl, output bit bne);
    legal = 0; wr = 0; src = 0; ctl = 0; bne = 0;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      legal = 1; wr = 1; src = 1;
    end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && (w[31:25] == 7'h00 || w[31:25] == 7'h20)) begin
      legal = 1; wr = 1; ctl = w[30];
    end else if (w[6:0] == 7'h63 && w[14:12] == 3'd1) begin
      legal = 1; ctl = 1; bne = 1;
    end
  endfunction

  function automatic logic [31:0] iimm(input logic [31:0] w);
    int v;
    v = int'(w[31:20]);
    if (w[31]) v -= 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] boff(input logic [31:0] w);
    int v;
    v = int'({w[7], w[30:25], w[11:8], 1'b0});
    if (w[31]) v -= 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rdi, input logic [4:0] ra, input logic [11:0] imm);
    return {imm, ra, 3'b000, rdi, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rdi, input logic [4:0] ra, input logic [4:0] rb, input bit sub);
    return {sub ? 7'b0100000 : 7'b0000000, rb, ra, 3'b000, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] ra, input logic [4:0] rb, input int off);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], rb, ra, 3'b001, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    e_halt_on = 0; e_pc_on = 0; e_addr_on = 0; e_rs1_on = 0; e_rs2_on = 0;
    e_rd_on = 0; e_imm_on = 0; e_alu_on = 0; e_lit = 0;
  endtask

  task automatic exp_reset();
    clear_exp();
    e_on = 1; e_req = 0; e_rw = 0;
    e_rs1_on = 1; e_rs2_on = 1; e_rd_on = 1; e_imm_on = 1; e_alu_on = 1;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_imm = '0; e_src = 0; e_ctrl = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1; imem_ack = 1;
    exp_reset();
    repeat (n) cyc();
    rst = 0; imem_ack = 0; e_on = 0;
    m_pc = 32'h0;
  endtask

  task automatic run_instr(input logic [31:0] w, input int waits, input bit eq,
                           input bit rst_exec, output bit trapped);
    bit legal, wr, src, ctl, bne;
    model(w, legal, wr, src, ctl, bne);
    trapped = 0;
    clear_exp();
    e_on = 1; e_req = 1; e_rw = 0; e_halt_on = 1; e_halted = 0;
    e_pc_on = 1; e_pc = m_pc; e_addr_on = 1; e_addr = m_pc;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 0; imem_rdata = $urandom; cyc();
    end
    imem_ack = 1; imem_rdata = w; cyc();
    imem_ack = 0; imem_rdata = $urandom; eq_out = eq;
    if (rst_exec) begin
      rst = 1; exp_reset(); cyc();
      rst = 0; e_on = 0; lit_kind = 0;
      m_pc = 32'h0;
      return;
    end
    clear_exp();
    e_on = 1; e_req = 0; e_rw = legal & wr; e_halt_on = 1; e_halted = 0;
    e_pc_on = 1; e_pc = m_pc;
    e_rs1_on = legal; e_rs1 = {1'b0, w[19:15]};
    e_rs2_on = legal & !src; e_rs2 = {1'b0, w[24:20]};
    e_rd_on = legal & !bne; e_rd = {1'b0, w[11:7]};
    e_imm_on = legal & src; e_imm = iimm(w);
    e_alu_on = legal; e_src = src; e_ctrl = ctl;
    e_lit = lit_kind;
    cyc();
    e_on = 0; lit_kind = 0;
    if (legal) m_pc = (bne && !eq) ? m_pc + boff(w) : m_pc + 32'd4;
    else begin
`ifdef FETCH_CTRL_TRAP_EN
      trapped = 1;
`else
      m_pc = m_pc + 32'd4;
`endif
    end
    m_pc[1:0] = 2'b00;
  endtask

  task automatic pc_lit(input string name, input logic [31:0] exp_v);
    @(negedge clk);
    check(name, imem_addr, exp_v);
    @(posedge clk);
    #1;
  endtask

`ifdef FETCH_CTRL_TRAP_EN
  task automatic halt_phase();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      clear_exp();
      e_on = 1; e_req = 0; e_rw = 0; e_halt_on = 1; e_halted = 1;
      e_pc_on = 1; e_pc = m_pc;
      cyc();
    end
    e_on = 0; imem_ack = 0;
  endtask
`endif

  bit          t;
  logic [31:0] w, f7;
  int          kind, waits;
  bit          eq, rex;

  initial begin
    rst = 1; imem_ack = 1; eq_out = 0; imem_rdata = '0; e_on = 0; lit_kind = 0; m_pc = '0;
    clear_exp();

    do_reset(3);

    lit_kind = 1; lit_rd = 6'd10; lit_imm = 32'd5; lit_src = 1; lit_ctrl = 0; lit_rw = 1;
    run_instr(32'h0050_0513, 2, 0, 0, t);
    pc_lit("pc_after_addi", 32'h4);

    lit_kind = 2; lit_rs1 = 6'd6; lit_rs2 = 6'd7; lit_rd = 6'd5; lit_src = 0; lit_ctrl = 1; lit_rw = 1;
    run_instr(32'h4073_02B3, 1, 1, 0, t);
    pc_lit("pc_after_sub", 32'h8);

    run_instr(enc_i(5'd1, 5'd1, 12'd1), 0, 0, 0, t);
    run_instr(enc_i(5'd1, 5'd1, 12'd1), 0, 0, 0, t);
    run_instr(enc_b(5'd1, 5'd2, -8), 0, 0, 0, t);
    pc_lit("bne_taken_addr", 32'h8);
    run_instr(enc_i(5'd1, 5'd1, 12'd1), 0, 0, 0, t);
    run_instr(enc_i(5'd1, 5'd1, 12'd1), 3, 0, 0, t);
    run_instr(enc_b(5'd1, 5'd2, -8), 1, 1, 0, t);
    pc_lit("bne_not_taken_addr", 32'h14);

    run_instr(32'hFFFF_FFFF, 0, 0, 0, t);
`ifdef FETCH_CTRL_TRAP_EN
    halt_phase();
    @(negedge clk);
    check("halt_pc_literal", pc, 32'h14);
    check("halt_req_literal", imem_req, 1'b0);
    @(posedge clk);
    #1;
`else
    pc_lit("illegal_nop_addr", 32'h18);
`endif
    do_reset(1);

    run_instr(enc_b(5'd0, 5'd0, -4), 0, 0, 0, t);
    pc_lit("pc_neg_addr", 32'hFFFF_FFFC);
    run_instr(enc_i(5'd3, 5'd0, 12'd7), 1, 0, 0, t);
    pc_lit("pc_wrap_addr", 32'h0);
    run_instr(enc_i(5'd3, 5'd0, 12'd7), 0, 0, 0, t);
    run_instr(enc_i(5'd4, 5'd0, 12'd9), 0, 0, 1, t);
    pc_lit("pc_after_rst_in_exec", 32'h0);

    for (int n = 0; n < 300; n++) begin
      kind  = $urandom_range(0, 5);
      waits = $urandom_range(0, 3);
      eq    = 1'($urandom_range(0, 1));
      rex   = ($urandom_range(0, 39) == 0);
      case (kind)
        0: w = enc_i(5'($urandom), 5'($urandom), 12'($urandom));
        1: w = enc_r(5'($urandom), 5'($urandom), 5'($urandom), 0);
        2: w = enc_r(5'($urandom), 5'($urandom), 5'($urandom), 1);
        3: w = enc_b(5'($urandom), 5'($urandom), (int'($urandom_range(0, 64)) - 32) * 2);
        4: w = $urandom;
        default: begin
          f7 = $urandom_range(1, 127);
          w  = enc_r(5'($urandom), 5'($urandom), 5'($urandom), 0) | (f7 << 25);
        end
      endcase
      run_instr(w, waits, eq, rex, t);
`ifdef FETCH_CTRL_TRAP_EN
      if (t) begin
        halt_phase();
        do_reset(1);
      end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
